ifetch_prefetch: RTL
====================

// Module: ifetch_prefetch
// PURPOSE
//  Parametrised fetch stage with request/response instruction-memory port and a DEPTH-entry prefetch FIFO.
//  Sits between the PC/redirect logic (EX/branch resolve) and the IF/ID register.
//  Supports decode back-pressure (stall), redirect flush and variable-latency in-order memory responses.
// PARAMETERS
//  XLEN      32           address/instruction width
//  DEPTH     4            prefetch FIFO entries (power of 2, >=2)
//  MAX_OUT   2            max outstanding memory requests (1..DEPTH)
//  RESET_PC  32'h0000_0000  PC loaded on reset
// PORTS
//  clk             in   1      clock, all state on rising edge
//  reset           in   1      asynchronous, active-low reset
//  pc_jump_i       in   XLEN   redirect target
//  pc_jump_en_i    in   1      redirect strobe (1 cycle)
//  imem_req_valid  out  1      fetch request valid
//  imem_req_ready  in   1      memory accepts request
//  imem_req_addr   out  XLEN   fetch address (word aligned)
//  imem_rsp_valid  in   1      response valid (in order, no back-pressure)
//  imem_rsp_data   in   XLEN   fetched instruction
//  instr_valid_o   out  1      FIFO head valid toward decode
//  instr_ready_i   in   1      decode accepts head (0 = stall)
//  instr_o         out  XLEN   head instruction
//  pc_out          out  XLEN   PC of head instruction
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, epoch=0; imem_req_valid=0, instr_valid_o=0, instr_o=0, pc_out=0.
//  - Issue: imem_req_valid=1 iff (fifo_count + outstanding) < DEPTH and outstanding < MAX_OUT and !pc_jump_en_i.
//    imem_req_addr=fetch_pc. On valid&ready: fetch_pc+=4, outstanding++, push {fetch_pc,epoch} to in-flight tag queue (MAX_OUT deep).
//  - Response: on imem_rsp_valid, pop tag; if tag.epoch==epoch push {pc,data} into FIFO, else drop. outstanding--.
//    Credit rule above guarantees FIFO never overflows; a response with outstanding==0 is illegal (assert).
//  - Issue and response in the same cycle: outstanding unchanged.
//  - Output: instr_valid_o = !empty; instr_o/pc_out = head (0 when empty). Pop on instr_valid_o & instr_ready_i.
//    Minimum latency request-accept -> instr_valid_o: memory latency + 1 cycle (FIFO registered write).
//  - Redirect (pc_jump_en_i=1): next cycle fetch_pc=pc_jump_i&~3, FIFO emptied, epoch toggled; no request issued
//    that cycle; responses for old epoch still decrement outstanding but are discarded. Redirect wins over
//    simultaneous pop/push; a pop of the old head in that cycle is still honoured by decode.
//  - Back-to-back redirects: each toggles epoch; epoch is ceil(log2(MAX_OUT+1)) bits, so no stale response matches.
//  - Stall: instr_ready_i=0 holds head stable; fetching continues until credits exhausted.
//  - fetch_pc wraps modulo 2^XLEN.
//  - Reset asserted mid-transaction: all state cleared immediately; responses arriving while outstanding==0
//    after reset release are ignored.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined: adds outputs perf_fetch_o[31:0] (instructions popped to decode) and
//    perf_flush_o[31:0] (redirects plus dropped stale responses, each counts 1); both reset to 0, saturate at 2^32-1.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  defines.v: `XLEN_DEF, `RESET_PC_DEF, instruction-width/NOP constants, epoch-width macro.
//  Sub-module ifetch_fifo (DEPTH x (2*XLEN), sync push/pop, clear, count out); reused for the tag queue.
//  Top holds fetch_pc, outstanding counter, epoch, credit logic.
// TESTING
//  1 Reset, 1-cycle memory, ready=1 always -> addresses 0,4,8,...; instr_valid_o from cycle 2, one instr/cycle.
//  2 instr_ready_i=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; head PC 0 held.
//  3 3-cycle memory latency, MAX_OUT=2 -> never >2 outstanding; in-order PCs, no duplicates or gaps.
//  4 Redirect to 32'h100 with 2 requests in flight -> both responses dropped, next pc_out=32'h100.
//  5 Redirects on consecutive cycles (0x200 then 0x300) -> first instruction delivered is from 0x300.
//  6 Reset asserted while 2 outstanding -> outputs 0 immediately; fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/ifetch_prefetch_pkg.sv
// Shared constants and helpers for the instruction-fetch prefetch stage.
package ifetch_prefetch_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_KEEP,
        RSP_DROP
    } rsp_kind_e;

    // Wide enough that MAX_OUT back-to-back redirects never alias an in-flight tag.
    function automatic int unsigned epoch_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/ifetch_prefetch_fifo.sv
// Synchronous FIFO with clear and occupancy count; used for the prefetch
// buffer and for the in-flight request tag queue.
module ifetch_prefetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_prefetch.sv
// Fetch stage: credit-limited request issue, epoch-tagged in-order responses,
// DEPTH-entry prefetch FIFO toward decode. Define IFETCH_PERF_CNT_EN for perf counters.
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int unsigned      XLEN     = XLEN_DEF,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_jump_i,
    input  logic            pc_jump_en_i,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_out
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_flush_o
`endif
);

    localparam int unsigned EW  = epoch_width(MAX_OUT);
    localparam int unsigned FCW = $clog2(DEPTH + 1);
    localparam int unsigned OCW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
    logic [EW-1:0]        epoch_q, epoch_d;
    logic [FCW-1:0]       fifo_count;
    logic [OCW-1:0]       outstanding;
    logic [2*XLEN-1:0]    fifo_head;
    logic [XLEN+EW-1:0]   tag_head;
    logic                 req_fire, rsp_take, fifo_push, fifo_pop;
    rsp_kind_e            rsp_kind;

    always_comb begin
        imem_req_valid = reset
                       && ((32'(fifo_count) + 32'(outstanding)) < DEPTH)
                       && (32'(outstanding) < MAX_OUT)
                       && !pc_jump_en_i;
        req_fire  = imem_req_valid && imem_req_ready;
        rsp_take  = imem_rsp_valid && (outstanding != '0);
        rsp_kind  = RSP_NONE;
        if (rsp_take) begin
            rsp_kind = (tag_head[EW-1:0] == epoch_q) ? RSP_KEEP : RSP_DROP;
        end
        // A redirect clears the FIFO, so a same-cycle current-epoch response is lost too.
        fifo_push = (rsp_kind == RSP_KEEP) && !pc_jump_en_i;
        fifo_pop  = instr_valid_o && instr_ready_i;

        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        if (pc_jump_en_i) begin
            fetch_pc_d = {pc_jump_i[XLEN-1:2], 2'b00};
            epoch_d    = epoch_q + EW'(1);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
        end
    end

    ifetch_prefetch_fifo #(.WIDTH(XLEN + EW), .DEPTH(MAX_OUT)) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data ({fetch_pc_q, epoch_q}),
        .pop       (rsp_take),
        .count     (outstanding),
        .head      (tag_head)
    );

    ifetch_prefetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_instr_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (pc_jump_en_i),
        .push      (fifo_push),
        .push_data ({tag_head[XLEN+EW-1:EW], imem_rsp_data}),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign imem_req_addr = fetch_pc_q;
    assign instr_valid_o = (fifo_count != '0);
    assign instr_o       = instr_valid_o ? fifo_head[XLEN-1:0]      : '0;
    assign pc_out        = instr_valid_o ? fifo_head[2*XLEN-1:XLEN] : '0;

    a_rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset) !(imem_rsp_valid && (outstanding == '0)));

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [32:0] fetch_sum, flush_sum;

    always_comb begin
        fetch_sum    = {1'b0, perf_fetch_q} + 33'(fifo_pop);
        flush_sum    = {1'b0, perf_flush_q} + 33'(pc_jump_en_i) + 33'(rsp_kind == RSP_DROP);
        perf_fetch_d = fetch_sum[32] ? '1 : fetch_sum[31:0];
        perf_flush_d = flush_sum[32] ? '1 : flush_sum[31:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_flush_o = perf_flush_q;
`else
    // Without counters, stale responses are still discarded via rsp_kind.
`endif

endmodule
